// File: rtl/add_acc_lanes.sv
// add_acc_lanes: multi-lane accumulate/write-back stage with forwarding.
// Optional macro ADD_SAT_EN: saturating ACC instead of modulo wrap.
module add_acc_lanes #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8,
   parameter int LANES  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [1:0]               in_mode,
   input  logic [LANES-1:0]         in_lane_en,
   input  logic [LANES*DATA_W-1:0]  in_act_value,
   input  logic [LANES*DATA_W-1:0]  in_mult_result,
   input  logic [LANES*ADDR_W-1:0]  in_act_addr,
   output logic                     wb_valid,
   input  logic                     wb_ready,
   output logic [LANES-1:0]         out_act_write_en,
   output logic [LANES*ADDR_W-1:0]  out_act_addr_wb,
   output logic [LANES*DATA_W-1:0]  add_result_wb
);

   localparam logic [1:0] M_IDLE = 2'b00;
   localparam logic [1:0] M_ACC  = 2'b01;
   localparam logic [1:0] M_LOAD = 2'b10;
   localparam logic [1:0] M_CLR  = 2'b11;

   logic                    wb_valid_q, wb_valid_d;
   logic [LANES-1:0]        lane_vld_q, lane_vld_d;
   logic [LANES*ADDR_W-1:0] addr_q, addr_d;
   logic [LANES*DATA_W-1:0] res_q, res_d;
   logic [LANES*DATA_W-1:0] res_new;
   logic                    accept, commit, load_beat;
   logic [DATA_W-1:0]       op_a, op_b, sum;

   assign in_ready  = !wb_valid_q || wb_ready;
   assign accept    = in_valid && in_ready;
   assign commit    = wb_valid_q && wb_ready;
   assign load_beat = (in_mode != M_IDLE) && (|in_lane_en);

   assign wb_valid         = wb_valid_q;
   assign out_act_write_en = lane_vld_q & {LANES{commit}};
   assign out_act_addr_wb  = addr_q;
   assign add_result_wb    = res_q;

   // Per-lane operand select (same-lane forwarding) and mode result.
   always_comb begin
      res_new = '0;
      op_a    = '0;
      op_b    = '0;
      sum     = '0;
      for (int i = 0; i < LANES; i++) begin
         op_b = in_mult_result[i*DATA_W +: DATA_W];
         if (wb_valid_q && lane_vld_q[i] &&
             (addr_q[i*ADDR_W +: ADDR_W] == in_act_addr[i*ADDR_W +: ADDR_W]))
            op_a = res_q[i*DATA_W +: DATA_W];
         else
            op_a = in_act_value[i*DATA_W +: DATA_W];
         sum = op_a + op_b;
`ifdef ADD_SAT_EN
         // Same-sign operands with a flipped result sign overflowed.
         if ((op_a[DATA_W-1] == op_b[DATA_W-1]) &&
             (sum[DATA_W-1] != op_a[DATA_W-1]))
            sum = op_a[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                 : {1'b0, {(DATA_W-1){1'b1}}};
`endif
         case (in_mode)
            M_ACC:   res_new[i*DATA_W +: DATA_W] = sum;
            M_LOAD:  res_new[i*DATA_W +: DATA_W] = op_b;
            M_CLR:   res_new[i*DATA_W +: DATA_W] = '0;
            default: res_new[i*DATA_W +: DATA_W] = '0;
         endcase
      end
   end

   // Write-back register next state: load on accept, drain on commit.
   always_comb begin
      wb_valid_d = wb_valid_q;
      lane_vld_d = lane_vld_q;
      addr_d     = addr_q;
      res_d      = res_q;
      if (accept) begin
         if (load_beat) begin
            wb_valid_d = 1'b1;
            lane_vld_d = in_lane_en;
            addr_d     = in_act_addr;
            res_d      = res_new;
         end else begin
            wb_valid_d = 1'b0;
            lane_vld_d = '0;
         end
      end else if (commit) begin
         wb_valid_d = 1'b0;
         lane_vld_d = '0;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wb_valid_q <= 1'b0;
         lane_vld_q <= '0;
         addr_q     <= '0;
         res_q      <= '0;
      end else begin
         wb_valid_q <= wb_valid_d;
         lane_vld_q <= lane_vld_d;
         addr_q     <= addr_d;
         res_q      <= res_d;
      end
   end

endmodule
